// File: rtl/cic_comp_pkg.sv
// Shared widths, compensation coefficients and FSM states
// for the CIC droop-compensation FIR.
package cic_comp_pkg;

    localparam int NIN_D   = 17;
    localparam int NOUT_D  = 16;
    localparam int NCOEF_D = 16;
    localparam int NTAP_D  = 7;
    localparam int SHIFT_D = 14;

    // Half plus centre of the symmetric Q1.14 response
    localparam logic signed [NCOEF_D-1:0] COEF [(NTAP_D+1)/2] = '{
        -16'sd328, 16'sd1311, -16'sd4260, 16'sd23170
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

endpackage

// File: rtl/cic_comp_fir_if.sv
// Sample-in / sample-out bundle of the compensation FIR.
// master drives samples in, slave is the filter.
interface cic_comp_fir_if #(
    parameter int NIN  = 17,
    parameter int NOUT = 16
);
    logic                   in_valid;
    logic signed [NIN-1:0]  din;
    logic                   in_ready;
    logic                   out_valid;
    logic signed [NOUT-1:0] dout;
    logic                   out_sat;
    logic                   overrun;

    modport master (
        output in_valid, din,
        input  in_ready, out_valid, dout, out_sat, overrun
    );

    modport slave (
        input  in_valid, din,
        output in_ready, out_valid, dout, out_sat, overrun
    );
endinterface

// File: rtl/cic_comp_mac.sv
// Pre-adder, multiplier and accumulator shared by all taps.
// clr has priority over en.
module cic_comp_mac
    import cic_comp_pkg::*;
#(
    parameter int NIN   = NIN_D,
    parameter int NCOEF = NCOEF_D,
    parameter int AW    = 36
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [NIN-1:0]   a,
    input  logic signed [NIN-1:0]   b,
    input  logic signed [NCOEF-1:0] coef,
    output logic signed [AW-1:0]    acc
);
    localparam int PW = NIN + 1 + NCOEF;

    logic signed [NIN:0]   pre;
    logic signed [PW-1:0]  prod;

    assign pre  = (NIN+1)'(a) + (NIN+1)'(b);
    assign prod = PW'(pre) * PW'(coef);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + AW'(prod);
        end
    end
endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: symmetric taps folded onto one
// pre-adder/multiplier, then round half up and saturate.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int NIN   = NIN_D,
    parameter int NOUT  = NOUT_D,
    parameter int NCOEF = NCOEF_D,
    parameter int NTAP  = NTAP_D,
    parameter int SHIFT = SHIFT_D
) (
    input logic           clk,
    input logic           rstn,
    cic_comp_fir_if.slave bus
);
    localparam int C  = (NTAP - 1) / 2;
    localparam int IW = (C < 1) ? 1 : $clog2(C + 1);
    localparam int AW = NIN + 1 + NCOEF + $clog2(C + 1);

    localparam logic signed [AW-1:0] MAXV = AW'((1 <<< (NOUT - 1)) - 1);
    localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
    localparam logic signed [AW-1:0] HALF = AW'(1 <<< (SHIFT - 1));

    state_t                  state;
    logic [IW-1:0]           idx;
    logic signed [NIN-1:0]   tap [NTAP];
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic signed [NOUT-1:0]  dout_r;
    logic                    out_sat_r;
    logic                    overrun_r;

    logic                    accept;
    logic signed [NIN-1:0]   pa;
    logic signed [NIN-1:0]   pb;
    logic signed [NCOEF-1:0] cf;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    sh;
    logic signed [NOUT-1:0]  dnext;
    logic                    snext;

    assign accept = (state == IDLE) && bus.in_valid;

    // Fold tap[idx] with its mirror; the centre tap has no partner
    always_comb begin
        pa = '0;
        pb = '0;
        cf = '0;
        for (int k = 0; k <= C; k++) begin
            if (idx == IW'(k)) begin
                pa = tap[k];
                pb = (k == C) ? '0 : tap[NTAP-1-k];
                cf = COEF[k];
            end
        end
    end

    cic_comp_mac #(
        .NIN   (NIN),
        .NCOEF (NCOEF),
        .AW    (AW)
    ) u_mac (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (state == MAC),
        .a    (pa),
        .b    (pb),
        .coef (cf),
        .acc  (acc)
    );

    always_comb begin
        sh    = (acc + HALF) >>> SHIFT;
        dnext = sh[NOUT-1:0];
        snext = 1'b0;
        if (sh > MAXV) begin
            dnext = MAXV[NOUT-1:0];
            snext = 1'b1;
        end else if (sh < MINV) begin
            dnext = MINV[NOUT-1:0];
            snext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            idx         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            out_sat_r   <= 1'b0;
            overrun_r   <= 1'b0;
            for (int k = 0; k < NTAP; k++) tap[k] <= '0;
        end else begin
            out_valid_r <= 1'b0;
            if (bus.in_valid && !in_ready_r) overrun_r <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        tap[0] <= bus.din;
                        for (int k = 1; k < NTAP; k++) tap[k] <= tap[k-1];
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    if (idx == IW'(C)) state <= OUT;
                    else idx <= idx + IW'(1);
                end
                OUT: begin
                    dout_r      <= dnext;
                    out_sat_r   <= snext;
                    out_valid_r <= 1'b1;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.out_sat   = out_sat_r;
    assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: reset, impulse, DC step,
// saturation, overrun, back-to-back and mid-MAC reset.
module tb_cic_comp_fir;
    import cic_comp_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int errors = 0;
    int checks = 0;

    cic_comp_fir_if #(.NIN(NIN_D), .NOUT(NOUT_D)) bus ();

    cic_comp_fir dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; sample is taken at the next edge
    task automatic strobe(input logic signed [16:0] x);
        bus.in_valid = 1'b1;
        bus.din      = x;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // n counts edges from the accepting edge (n=1) to out_valid
    task automatic wait_out(output int n);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic send(input logic signed [16:0] x, input int exp,
                        input logic exp_sat, input string tag);
        int n;
        strobe(x);
        wait_out(n);
        chk({tag, "_lat"}, n, 6);
        chk({tag, "_dout"}, longint'(bus.dout), exp);
        chk({tag, "_sat"}, bus.out_sat, exp_sat);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    int imp_exp [8] = '{-328, 1311, -4260, 23170, -4260, 1311, -328, 0};
    int dc_exp  [7] = '{-328, 983, -3277, 19893, 15633, 16944, 16616};
    int hi_exp  [7] = '{-1312, 3932, -13108, 32767, 32767, 32767, 32767};
    int lo_exp  [7] = '{1312, -3932, 13108, -32768, -32768, -32768, -32768};
    logic sat_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        int n;
        int stray;
        bus.in_valid = 1'b0;
        bus.din      = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_dout", longint'(bus.dout), 0);
        chk("rst_overrun", bus.overrun, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Impulse with idle gaps between samples
        for (int i = 0; i < 8; i++) begin
            send((i == 0) ? 17'sd16384 : 17'sd0, imp_exp[i], 1'b0,
                 $sformatf("imp%0d", i));
            repeat (2) @(posedge clk);
            #1;
        end
        chk("imp_hold_dout", longint'(bus.dout), 0);
        chk("imp_overrun", bus.overrun, 0);

        // DC step, each sample presented in the out_valid cycle
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) chk($sformatf("dc%0d_ready", i), bus.in_ready, 1);
            send(17'sd16384, dc_exp[i], 1'b0, $sformatf("dc%0d", i));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("dc_hold_dout", longint'(bus.dout), 16616);
        chk("dc_overrun", bus.overrun, 0);

        do_reset();
        for (int i = 0; i < 7; i++)
            send(17'sd65535, hi_exp[i], sat_exp[i], $sformatf("hi%0d", i));

        do_reset();
        for (int i = 0; i < 7; i++)
            send(-17'sd65536, lo_exp[i], sat_exp[i], $sformatf("lo%0d", i));
        chk("sat_overrun", bus.overrun, 0);

        // Second strobe while busy must be dropped
        do_reset();
        strobe(17'sd16384);
        @(posedge clk); #1;
        strobe(17'sd1000);
        chk("ovr_flag", bus.overrun, 1);
        wait_out(n);
        chk("ovr_out_valid", bus.out_valid, 1);
        chk("ovr_dout", longint'(bus.dout), -328);
        send(17'sd0, 1311, 1'b0, "ovr_next");
        chk("ovr_sticky", bus.overrun, 1);

        // Reset in the middle of a computation
        strobe(17'sd16384);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("mid_in_ready", bus.in_ready, 1);
        chk("mid_out_valid", bus.out_valid, 0);
        chk("mid_dout", longint'(bus.dout), 0);
        chk("mid_overrun", bus.overrun, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        stray = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) stray++;
        end
        chk("mid_stray", stray, 0);
        send(17'sd16384, -328, 1'b0, "mid_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
